// File: rtl/router_pkg.sv
// router_pkg: constants and types shared by the request-bus slave logic.
//   CMD_READ / CMD_WRITE      : encoding of the 1-bit cmd field
//   REGION_MSB / REGION_LSB   : position of the slave region id inside addr
//   resp_state_t              : slave responder FSM states
package router_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int unsigned REGION_MSB = 31;
    localparam int unsigned REGION_LSB = 30;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        GAP
    } resp_state_t;

endpackage

// File: rtl/rd_delay_line.sv
// rd_delay_line: fixed-latency valid+data shift register for read responses.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : a read result enters the line this cycle
//   i_data    : read data accompanying i_push
//   o_resp    : pulses DEPTH cycles after i_push
//   o_rdata   : data of the last delivered read, held between responses
module rd_delay_line #(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_resp,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DEPTH-1:0]      r_vld;
    logic [DATA_WIDTH-1:0] r_data [DEPTH];

    // Data only moves along with a valid entry, so the last stage keeps the
    // most recently delivered word after resp drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_push;
            if (i_push) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_resp  = r_vld[DEPTH-1];
    assign o_rdata = r_data[DEPTH-1];

endmodule

// File: rtl/slave_responder.sv
// slave_responder: slave endpoint of the master/slave request bus, backed by a
// local word memory. Writes complete on accept; reads return rdata with a resp
// pulse RD_LATENCY cycles after the ack cycle, in acceptance order.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request valid, held by the master until ack
//   addr     : request address; [31:30] region id, [MEM_DEPTH_EXP-1:0] word index
//   cmd      : 0 = read, 1 = write
//   wdata    : write data
//   ack      : one-cycle accept pulse
//   resp     : one-cycle read-response pulse
//   rdata    : read data, valid with resp and held afterwards
module slave_responder
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned MEM_DEPTH_EXP = 8,
    parameter int unsigned ACK_WAIT      = 2,
    parameter int unsigned RD_LATENCY    = 3,
    parameter int unsigned SLAVE_N       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cmd,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned MEM_WORDS = 1 << MEM_DEPTH_EXP;

    resp_state_t              r_state, w_state_d;
    logic [3:0]               r_cnt, w_cnt_d;
    logic [MEM_DEPTH_EXP-1:0] r_idx;
    logic                     r_cmd;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rd_data;
    logic [DATA_WIDTH-1:0]    r_mem [MEM_WORDS];

    logic                     w_hit;
    logic                     w_do_op;
    logic                     w_push;
    logic [MEM_DEPTH_EXP-1:0] w_op_idx;
    logic                     w_op_cmd;
    logic [DATA_WIDTH-1:0]    w_op_wdata;
    logic                     w_unused_addr;

    // Only the region field and the word index are decoded.
    assign w_unused_addr = ^addr;

    assign w_hit = (addr[REGION_MSB:REGION_LSB] == 2'(SLAVE_N));

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (req && w_hit) begin
                    w_cnt_d   = 4'(ACK_WAIT);
                    w_state_d = (ACK_WAIT == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    // Master withdrew: abort with no memory effect.
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_d = ACK;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            ACK:     w_state_d = GAP;
            // req is still high here while the master reacts to ack.
            GAP:     w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // The memory operation fires on the edge entering ACK. With ACK_WAIT=0
    // that edge is the same one that latches the request, so take the fields
    // straight from the bus in that case.
    assign w_do_op    = (w_state_d == ACK);
    assign w_op_idx   = (r_state == IDLE) ? addr[MEM_DEPTH_EXP-1:0] : r_idx;
    assign w_op_cmd   = (r_state == IDLE) ? cmd : r_cmd;
    assign w_op_wdata = (r_state == IDLE) ? wdata : r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_cmd     <= CMD_READ;
            r_wdata   <= '0;
            r_rd_data <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (r_state == IDLE && w_state_d != IDLE) begin
                r_idx   <= addr[MEM_DEPTH_EXP-1:0];
                r_cmd   <= cmd;
                r_wdata <= wdata;
            end
            // Captured before any later write can touch the word.
            if (w_do_op) begin
                r_rd_data <= r_mem[w_op_idx];
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_op && w_op_cmd == CMD_WRITE) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    assign ack    = (r_state == ACK);
    assign w_push = (r_state == ACK) && (r_cmd == CMD_READ);

    rd_delay_line #(
        .DEPTH      (RD_LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_delay_line (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_rd_data),
        .o_resp  (resp),
        .o_rdata (rdata)
    );

endmodule

// File: tb/tb_slave_responder.sv
// tb_slave_responder: self-checking bench for slave_responder. Two instances:
// dut1 (ACK_WAIT=2, RD_LATENCY=3) and dut2 (ACK_WAIT=4, RD_LATENCY=8, long
// enough for a write to be accepted while a read is still in flight).
module tb_slave_responder;
    import router_pkg::*;

    localparam int AW1 = 2;
    localparam int RL1 = 3;
    localparam int AW2 = 4;
    localparam int RL2 = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, cmd1, ack1, resp1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        req2, cmd2, ack2, resp2;
    logic [31:0] addr2, wdata2, rdata2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_ack1   = 0;
    int n_resp1  = 0;
    int n_ack2   = 0;
    int n_resp2  = 0;
    int base_ack;
    int base_resp;
    int ack_cyc[$];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    logic [31:0] m1 [256];
    logic [31:0] m2 [256];

    slave_responder #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .MEM_DEPTH_EXP (8),
        .ACK_WAIT      (AW1),
        .RD_LATENCY    (RL1),
        .SLAVE_N       (0)
    ) dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req1),
        .addr  (addr1),
        .cmd   (cmd1),
        .wdata (wdata1),
        .ack   (ack1),
        .resp  (resp1),
        .rdata (rdata1)
    );

    slave_responder #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .MEM_DEPTH_EXP (8),
        .ACK_WAIT      (AW2),
        .RD_LATENCY    (RL2),
        .SLAVE_N       (0)
    ) dut2 (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .addr  (addr2),
        .cmd   (cmd2),
        .wdata (wdata2),
        .ack   (ack2),
        .resp  (resp2),
        .rdata (rdata2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: the model memory is updated at write acks, reads push the
    // model value with the cycle their response is due.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp1) begin
                n_resp1++;
                if (q1.size() == 0) begin
                    check("dut1 unexpected resp", 1, 0);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1 rdata", rdata1, e1.data);
                    check("dut1 resp cycle", cyc, e1.due);
                end
            end
            if (ack1) begin
                n_ack1++;
                if (cmd1 == CMD_WRITE) begin
                    m1[addr1[7:0]] = wdata1;
                end else begin
                    e1.data = m1[addr1[7:0]];
                    e1.due  = cyc + RL1;
                    q1.push_back(e1);
                end
            end
            if (resp2) begin
                n_resp2++;
                if (q2.size() == 0) begin
                    check("dut2 unexpected resp", 1, 0);
                end else begin
                    e2 = q2.pop_front();
                    check("dut2 rdata", rdata2, e2.data);
                    check("dut2 resp cycle", cyc, e2.due);
                end
            end
            if (ack2) begin
                n_ack2++;
                if (cmd2 == CMD_WRITE) begin
                    m2[addr2[7:0]] = wdata2;
                end else begin
                    e2.data = m2[addr2[7:0]];
                    e2.due  = cyc + RL2;
                    q2.push_back(e2);
                end
            end
        end
    end

    // Call just after a posedge while the DUT is IDLE. The first negedge seen
    // is cycle 0; ack must arrive in cycle ACK_WAIT+1. With tail=1 the task
    // returns just after the posedge on which the DUT is back in IDLE.
    task automatic do_req(input int d, input logic [31:0] a, input logic c,
                          input logic [31:0] wd, input bit tail);
        int k;
        int aw;
        aw = (d == 0) ? AW1 : AW2;
        if (d == 0) begin
            addr1 = a; cmd1 = c; wdata1 = wd; req1 = 1'b1;
        end else begin
            addr2 = a; cmd2 = c; wdata2 = wd; req2 = 1'b1;
        end
        k = 0;
        while (k <= 50) begin
            @(negedge clk);
            if ((d == 0) ? ack1 : ack2) break;
            k++;
        end
        if (k > 50) check("ack timeout", 0, 1);
        else check("ack latency", k, aw + 1);
        req1 = 1'b0;
        req2 = 1'b0;
        if (tail) begin
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req1 = 1'b0; cmd1 = CMD_READ; addr1 = '0; wdata1 = '0;
        req2 = 1'b0; cmd2 = CMD_READ; addr2 = '0; wdata2 = '0;
        #1;
        check("reset ack1", ack1, 0);
        check("reset resp1", resp1, 0);
        check("reset rdata1", rdata1, 0);
        check("reset ack2", ack2, 0);
        check("reset resp2", resp2, 0);
        check("reset rdata2", rdata2, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read back, plus an aliased address (index wraps).
        base_resp = n_resp1;
        do_req(0, 32'h0000_0010, CMD_WRITE, 32'hDEAD_BEEF, 1'b1);
        settle(5);
        check("s1 no resp for write", n_resp1 - base_resp, 0);
        do_req(0, 32'h0000_0010, CMD_READ, 32'h0, 1'b1);
        settle(5);
        do_req(0, 32'h0000_0110, CMD_READ, 32'h0, 1'b1);
        settle(5);
        check("s1 resp count", n_resp1 - base_resp, 2);
        check("s1 rdata held", rdata1, 32'hDEAD_BEEF);

        // Write-after-read: the in-flight read keeps the old value.
        base_resp = n_resp2;
        do_req(1, 32'h0000_0005, CMD_WRITE, 32'h0000_AAAA, 1'b1);
        do_req(1, 32'h0000_0005, CMD_READ, 32'h0, 1'b1);
        do_req(1, 32'h0000_0005, CMD_WRITE, 32'h0000_1234, 1'b1);
        do_req(1, 32'h0000_0005, CMD_READ, 32'h0, 1'b1);
        settle(12);
        check("s2 resp count", n_resp2 - base_resp, 2);
        check("s2 rdata after hazard", rdata2, 32'h0000_1234);

        // Region mismatch is never acked and leaves the FSM in IDLE.
        base_ack  = n_ack1;
        base_resp = n_resp1;
        addr1 = 32'h4000_0000; cmd1 = CMD_WRITE; wdata1 = 32'h0BAD_0BAD; req1 = 1'b1;
        repeat (20) @(negedge clk);
        req1 = 1'b0;
        check("s3 no ack", n_ack1 - base_ack, 0);
        check("s3 no resp", n_resp1 - base_resp, 0);
        @(posedge clk);
        #1;
        do_req(0, 32'h0000_0010, CMD_READ, 32'h0, 1'b1);
        settle(5);

        // req held across accepts: one ack every ACK_WAIT+3 cycles.
        base_ack  = n_ack1;
        base_resp = n_resp1;
        ack_cyc.delete();
        addr1 = 32'h0000_0010; cmd1 = CMD_READ; req1 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ack1) ack_cyc.push_back(k);
        end
        req1 = 1'b0;
        check("s4 ack count", ack_cyc.size(), 6);
        if (ack_cyc.size() > 0) check("s4 first ack", ack_cyc[0], AW1 + 1);
        for (int i = 1; i < ack_cyc.size(); i++) begin
            check("s4 ack spacing", ack_cyc[i] - ack_cyc[i-1], AW1 + 3);
        end
        settle(8);
        check("s4 resp equals ack", n_resp1 - base_resp, n_ack1 - base_ack);

        // req dropped during WAIT: no ack, memory unchanged.
        do_req(1, 32'h0000_0020, CMD_WRITE, 32'h0000_5555, 1'b1);
        base_ack = n_ack2;
        addr2 = 32'h0000_0020; cmd2 = CMD_WRITE; wdata2 = 32'h0000_9999; req2 = 1'b1;
        repeat (3) @(negedge clk);
        req2 = 1'b0;
        repeat (10) @(negedge clk);
        check("s5 no ack after drop", n_ack2 - base_ack, 0);
        @(posedge clk);
        #1;
        do_req(1, 32'h0000_0020, CMD_READ, 32'h0, 1'b1);
        settle(10);
        check("s5 memory unchanged", rdata2, 32'h0000_5555);

        // Asynchronous reset one cycle after a read ack flushes the read.
        do_req(0, 32'h0000_0010, CMD_READ, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("s6 ack in reset", ack1, 0);
        check("s6 resp in reset", resp1, 0);
        check("s6 rdata in reset", rdata1, 0);
        q1.delete();
        q2.delete();
        base_resp = n_resp1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("s6 no resp after reset", n_resp1 - base_resp, 0);
        @(posedge clk);
        #1;
        do_req(0, 32'h0000_0010, CMD_WRITE, 32'hCAFE_F00D, 1'b1);
        do_req(0, 32'h0000_0010, CMD_READ, 32'h0, 1'b1);
        settle(6);
        check("s6 resp after reset", n_resp1 - base_resp, 1);
        check("s6 rdata after reset", rdata1, 32'hCAFE_F00D);

        check("dut1 scoreboard empty", q1.size(), 0);
        check("dut2 scoreboard empty", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
